// File: rtl/ex3_to_bcd_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex3_to_bcd_serial_pkg
// Description : Shared constants for the serial Excess-3 to BCD converter.
//               Holds the FSM state encoding and the Excess-3 code limits.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ex3_to_bcd_serial_pkg;

    // FSM state encoding (explicit 2-bit width)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Excess-3 code window and conversion constants
    localparam logic [3:0] EX3_MIN     = 4'h3;
    localparam logic [3:0] EX3_MAX     = 4'hC;
    localparam logic [3:0] EX3_OFFSET  = 4'h3;
    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage : ex3_to_bcd_serial_pkg
`default_nettype wire

// File: rtl/ex3_digit_dec.sv
`default_nettype none
// ============================================================================
// Module      : ex3_digit_dec
// Description : Combinational single-digit Excess-3 to BCD decoder.
//               Codes outside 3..12 produce BCD_INVALID and raise invalid.
// Ports       : ex3_digit [3:0] in  - Excess-3 code
//               bcd_digit [3:0] out - decoded BCD digit (or 4'hF)
//               invalid         out - code was not legal Excess-3
// Revision    : 1.0 - initial release
// ============================================================================
module ex3_digit_dec
    import ex3_to_bcd_serial_pkg::*;
(
    input  logic [3:0] ex3_digit,
    output logic [3:0] bcd_digit,
    output logic       invalid
);

    logic w_invalid;

    assign w_invalid = (ex3_digit < EX3_MIN) || (ex3_digit > EX3_MAX);
    assign invalid   = w_invalid;
    // Subtraction wraps in 4 bits; only legal codes ever reach the output.
    assign bcd_digit = w_invalid ? BCD_INVALID : (ex3_digit - EX3_OFFSET);

endmodule : ex3_digit_dec
`default_nettype wire

// File: rtl/ex3_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : ex3_to_bcd_serial
// Description : Accepts a word of NDIG packed Excess-3 digits, decodes one
//               digit per cycle through a single shared decoder and presents
//               the packed BCD result plus a per-digit error mask.
// Ports       : clk, rst_n (async, active-low)
//               in_valid/in_ready/ex3_in[4*NDIG-1:0]   - input handshake
//               out_valid/out_ready/bcd_out[4*NDIG-1:0],
//               err_mask[NDIG-1:0]                      - output handshake
//               busy                                    - FSM not in IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module ex3_to_bcd_serial
    import ex3_to_bcd_serial_pkg::*;
#(
    parameter int NDIG = 4
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   ex3_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     err_mask,
    output logic                busy
);

    localparam int              IDXW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NDIG - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [IDXW-1:0]    r_idx;
    logic [4*NDIG-1:0]  r_in_word;
    logic [4*NDIG-1:0]  r_result;
    logic [NDIG-1:0]    r_err;
    logic               r_in_ready;

    logic [3:0]         w_digit;
    logic [3:0]         w_bcd;
    logic               w_invalid;
    logic               w_accept;

    // Bit offset of the current digit is idx*4, formed by concatenation.
    assign w_digit  = r_in_word[{r_idx, 2'b00} +: 4];
    assign w_accept = in_valid && r_in_ready;

    ex3_digit_dec u_dec (
        .ex3_digit (w_digit),
        .bcd_digit (w_bcd),
        .invalid   (w_invalid)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)              w_state_next = CONV;
            CONV:    if (r_idx == C_LAST_IDX)   w_state_next = DONE;
            DONE:    if (out_ready)             w_state_next = IDLE;
            default:                            w_state_next = IDLE;
        endcase
    end

    // in_ready is registered from the next state so it is low while reset is
    // asserted and only rises on the first edge after release; this also
    // keeps in_valid out of the in_ready timing path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_in_word  <= '0;
            r_result   <= '0;
            r_err      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_in_ready <= (w_state_next == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_word <= ex3_in;
                        r_idx     <= '0;
                        r_result  <= '0;
                        r_err     <= '0;
                    end
                end
                CONV: begin
                    r_result[{r_idx, 2'b00} +: 4] <= w_bcd;
                    r_err[r_idx]                  <= w_invalid;
                    // Hold at the last digit rather than wrapping.
                    if (r_idx != C_LAST_IDX) begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign bcd_out   = r_result;
    assign err_mask  = r_err;

endmodule : ex3_to_bcd_serial
`default_nettype wire

// File: tb/tb_ex3_to_bcd_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex3_to_bcd_serial
// Description : Scoreboard bench for ex3_to_bcd_serial. A 4-digit instance
//               gets directed and random words; a 1-digit instance gets a
//               sweep of every 4-bit code. Expected results come from a
//               digit-by-digit arithmetic model of the Excess-3 rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex3_to_bcd_serial;

    localparam int NDIG = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ex3_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd_out;
    logic [3:0]  err_mask;
    logic        busy;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  ex3_in1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  bcd_out1;
    logic [0:0]  err_mask1;
    logic        busy1;

    logic rand_en  = 1'b0;
    logic rand_rdy = 1'b1;
    logic dir_rdy  = 1'b1;
    assign out_ready  = rand_en ? rand_rdy : dir_rdy;
    assign out_ready1 = 1'b1;

    ex3_to_bcd_serial #(.NDIG(NDIG)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .ex3_in(ex3_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .err_mask(err_mask), .busy(busy)
    );

    ex3_to_bcd_serial #(.NDIG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .ex3_in(ex3_in1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .bcd_out(bcd_out1), .err_mask(err_mask1), .busy(busy1)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    typedef struct {
        logic [31:0] bcd;
        logic [7:0]  err;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    logic prev_ov  = 1'b0;
    logic prev_ov1 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1 rand_rdy = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: each 4-bit field in 3..12 maps to value-3, anything else to
    // 15 with its error bit set.
    function automatic void ref_conv(input logic [31:0] w, input int nd,
                                     output logic [31:0] bcd, output logic [7:0] err);
        bcd = '0;
        err = '0;
        for (int i = 0; i < nd; i++) begin
            int v;
            v = int'((w >> (4 * i)) & 32'hF);
            if (v >= 3 && v <= 12) bcd = bcd | (32'(v - 3) << (4 * i));
            else begin
                bcd = bcd | (32'hF << (4 * i));
                err = err | 8'(1 << i);
            end
        end
    endfunction

    // Monitor / scoreboard for the 4-digit instance
    initial forever begin
        exp_t e;
        logic [31:0] b;
        logic [7:0]  er;
        @(negedge clk);
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                ref_conv({16'h0, ex3_in}, NDIG, b, er);
                e.bcd = b; e.err = er; e.acc = cyc + 1;
                q.push_back(e);
            end
            if (out_valid) begin
                if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                else begin
                    e = q[0];
                    if (!prev_ov) chk("latency", 32'(cyc - e.acc), 32'(NDIG));
                    chk("bcd_out", 32'(bcd_out), e.bcd);
                    chk("err_mask", 32'(err_mask), 32'(e.err));
                    if (out_ready) void'(q.pop_front());
                end
            end
            prev_ov = out_valid;
        end
    end

    // Monitor / scoreboard for the 1-digit instance
    initial forever begin
        exp_t e;
        logic [31:0] b;
        logic [7:0]  er;
        @(negedge clk);
        if (!rst_n) begin
            prev_ov1 = 1'b0;
        end else begin
            if (in_valid1 && in_ready1) begin
                ref_conv({28'h0, ex3_in1}, 1, b, er);
                e.bcd = b; e.err = er; e.acc = cyc + 1;
                q1.push_back(e);
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("unexpected_out_valid1", 32'(out_valid1), 32'd0);
                else begin
                    e = q1[0];
                    if (!prev_ov1) chk("latency1", 32'(cyc - e.acc), 32'd1);
                    chk("bcd_out1", 32'(bcd_out1), e.bcd);
                    chk("err_mask1", 32'(err_mask1), 32'(e.err));
                    if (out_ready1) void'(q1.pop_front());
                end
            end
            prev_ov1 = out_valid1;
        end
    end

    task automatic send(input logic [15:0] w);
        int t = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        ex3_in   = w;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ex3_in   = 16'($urandom);
    endtask

    task automatic send1(input logic [3:0] w);
        int t = 0;
        @(posedge clk);
        #1;
        in_valid1 = 1'b1;
        ex3_in1   = w;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready1 && t < 200);
        if (!in_ready1) chk("accept_timeout1", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || q1.size() != 0) && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", 32'(q.size() + q1.size()), 32'd0);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_bcd_out"},   32'(bcd_out),   32'd0);
        chk({tag, "_err_mask"},  32'(err_mask),  32'd0);
    endtask

    initial begin
        int t;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        ex3_in    = '0;
        in_valid1 = 1'b0;
        ex3_in1   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 chk("in_ready_after_edge", 32'(in_ready), 32'd1);

        // Directed words, out_ready held high
        send(16'h3456);
        send(16'hCCCC);
        send(16'h3333);
        send(16'h3D21);
        drain();

        // Backpressure: a second word is held on the input while DONE stalls
        dir_rdy = 1'b0;
        send(16'h5678);
        in_valid = 1'b1;
        ex3_in   = 16'h9A3B;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1 dir_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset in the middle of a conversion (idx = 2)
        send(16'h3456);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q.delete();
        #1 chk_reset_outputs("midrst");
        @(posedge clk);
        #1 chk("midrst_out_valid_hold", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        send(16'h4C3B);
        drain();

        // Random words with random backpressure and idle gaps
        rand_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] w;
            for (int d = 0; d < 4; d++) begin
                logic [3:0] dg;
                dg = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(3, 12));
                w[4*d +: 4] = dg;
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            send(w);
        end
        drain();
        rand_en = 1'b0;

        // Every 4-bit code through the single-digit instance
        for (int x = 0; x < 16; x++) send1(4'(x));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_ex3_to_bcd_serial
`default_nettype wire
